// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FWFT FIFO pointer/flag controller.
package fifo_ctrl_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } level_flags_t;

    localparam level_flags_t LEVEL_FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Occupancy-derived flags for a given count; evaluated on the next count so flags never lag.
    function automatic level_flags_t level_flags(
        input int unsigned cnt,
        input int unsigned depth,
        input int unsigned af,
        input int unsigned ae
    );
        level_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 0);
        f.almost_full  = (cnt >= af);
        f.almost_empty = (cnt <= ae);
        return f;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller turning a sync-write/async-read RAM into a first-word-fall-through FIFO.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned addr_width = 3,
    parameter int unsigned af_level   = 6,
    parameter int unsigned ae_level   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  we,
    output logic [addr_width-1:0] w_addr,
    output logic [addr_width-1:0] r_addr,
    output logic [addr_width:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** addr_width;
    localparam int unsigned CW    = addr_width + 1;

    logic [CW-1:0] w_ptr_q, w_ptr_d;
    logic [CW-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    level_flags_t  lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO is allowed when a pop frees the slot in the same cycle.
    always_comb begin
        push_ok = wr & (~lvl_q.full | rd);
        pop_ok  = rd & ~lvl_q.empty;
        w_ptr_d = w_ptr_q + CW'(push_ok);
        r_ptr_d = r_ptr_q + CW'(pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        lvl_d   = level_flags(32'(count_d), DEPTH, af_level, ae_level);
        ovf_d   = (wr & lvl_q.full & ~rd) | (ovf_q & ~clr_err);
        udf_d   = (rd & lvl_q.empty) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            lvl_q   <= LEVEL_FLAGS_RST;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign we           = push_ok;
    assign w_addr       = w_ptr_q[addr_width-1:0];
    assign r_addr       = r_ptr_q[addr_width-1:0];
    assign count        = count_q;
    assign full         = lvl_q.full;
    assign empty        = lvl_q.empty;
    assign almost_full  = lvl_q.almost_full;
    assign almost_empty = lvl_q.almost_empty;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized bench for fifo_ctrl with a local RAM and a queue-based FIFO reference model.
module tb_fifo_ctrl;

    localparam int AW  = 3;
    localparam int D   = 2 ** AW;
    localparam int AFL = 6;
    localparam int AEL = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr, rd, clr_err;
    logic          we;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    logic [7:0]    mem [D];
    logic [7:0]    w_data;
    logic [7:0]    r_data;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] q[$];
    int         wcnt, rcnt;
    logic       ovf_m, udf_m;

    fifo_ctrl #(
        .addr_width(AW),
        .af_level  (AFL),
        .ae_level  (AEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .clr_err     (clr_err),
        .we          (we),
        .w_addr      (w_addr),
        .r_addr      (r_addr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (we) mem[w_addr] <= w_data;
    end
    assign r_data = mem[r_addr];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt  = 0;
        rcnt  = 0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    task automatic check_regs();
        int n;
        n = q.size();
        chk_eq("count", 32'(count), n);
        chk_eq("full", 32'(full), 32'(n == D));
        chk_eq("empty", 32'(empty), 32'(n == 0));
        chk_eq("almost_full", 32'(almost_full), 32'(n >= AFL));
        chk_eq("almost_empty", 32'(almost_empty), 32'(n <= AEL));
        chk_eq("overflow", 32'(overflow), 32'(ovf_m));
        chk_eq("underflow", 32'(underflow), 32'(udf_m));
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        logic push, pop;
        int   n;
        wr      = w;
        rd      = r;
        clr_err = c;
        w_data  = d;
        #1;
        n    = q.size();
        push = w && (n < D || r);
        pop  = r && (n != 0);
        chk_eq("we", 32'(we), 32'(push));
        chk_eq("w_addr", 32'(w_addr), wcnt);
        chk_eq("r_addr", 32'(r_addr), rcnt);
        if (n != 0) chk_eq("r_data", 32'(r_data), 32'(q[0]));
        ovf_m = (w && n == D && !r) || (ovf_m && !c);
        udf_m = (r && n == 0) || (udf_m && !c);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        wcnt = (wcnt + int'(push)) % D;
        rcnt = (rcnt + int'(pop)) % D;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        int pw, pr;
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        w_data  = 8'h00;
        model_reset();
        #12;
        check_regs();
        chk_eq("we_rst", 32'(we), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Idle after reset
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill to full, then one dropped push
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b0, 1'b0, 8'h99);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain, one extra pop, then clear errors
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Full with simultaneous push/pop, pointers wrap
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        // Empty with simultaneous push/pop
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h00);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        wr = 1'b0;
        rd = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk_eq("we_arst", 32'(we), 32'd0);
        chk_eq("w_addr_arst", 32'(w_addr), 32'd0);
        chk_eq("r_addr_arst", 32'(r_addr), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Randomized phases biased toward full, toward empty, then balanced
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 75 : (ph == 1) ? 35 : 55;
            pr = (ph == 0) ? 35 : (ph == 1) ? 75 : 55;
            for (int i = 0; i < 250; i++) begin
                step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                     1'($urandom_range(0, 99) < 6), 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
